// File: rtl/mvm_arbiter.sv
// Round-robin arbiter sharing one 3x3 matrix-vector datapath among 4 requesters.
// Optional MVM_ARB_STATS_EN adds a 16-bit count of successful jobs (job_count).
`timescale 1ns/1ps
module mvm_arbiter #(
    parameter int unsigned WAIT_MAX = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [287:0] req_a,
    input  logic [95:0]  req_x,
    output logic [3:0]   gnt,
    output logic         dp_start,
    output logic [71:0]  dp_a,
    output logic [23:0]  dp_x,
    input  logic         dp_done,
    input  logic [47:0]  dp_y,
    output logic [3:0]   rsp_valid,
    output logic [47:0]  rsp_y,
    output logic         rsp_err,
    input  logic [3:0]   rsp_ready,
`ifdef MVM_ARB_STATS_EN
    output logic [15:0]  job_count,
`endif
    output logic         arb_busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [71:0] dp_a_q, dp_a_d;
    logic [23:0] dp_x_q, dp_x_d;
    logic [47:0] rsp_y_q, rsp_y_d;
    logic        rsp_err_q, rsp_err_d;
    logic        timeout;
    logic        ack;

    // Lowest offset from the pointer wins, so scan offsets downward.
    function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign timeout = (cnt_q == 8'(WAIT_MAX - 1));
    assign ack     = rsp_ready[owner_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            dp_a_q    <= '0;
            dp_x_q    <= '0;
            rsp_y_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            dp_a_q    <= dp_a_d;
            dp_x_q    <= dp_x_d;
            rsp_y_q   <= rsp_y_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        dp_a_d    = dp_a_q;
        dp_x_d    = dp_x_q;
        rsp_y_d   = rsp_y_q;
        rsp_err_d = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = rr_pick(req, ptr_q);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                dp_a_d  = req_a[72*owner_q +: 72];
                dp_x_d  = req_x[24*owner_q +: 24];
                state_d = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion takes priority over a coincident timeout.
                if (dp_done) begin
                    rsp_y_d   = dp_y;
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                end else if (timeout) begin
                    rsp_y_d   = '0;
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (ack) begin
                    ptr_d   = owner_q + 2'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt       = '0;
        rsp_valid = '0;
        dp_start  = (state_q == START);
        arb_busy  = (state_q != IDLE);
        if (state_q == GRANT) gnt = 4'b0001 << owner_q;
        if (state_q == RESP)  rsp_valid = 4'b0001 << owner_q;
    end

    assign dp_a    = dp_a_q;
    assign dp_x    = dp_x_q;
    assign rsp_y   = rsp_y_q;
    assign rsp_err = rsp_err_q;

`ifdef MVM_ARB_STATS_EN
    logic [15:0] job_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            job_cnt_q <= '0;
        end else if (state_q == RESP && ack && !rsp_err_q) begin
            job_cnt_q <= job_cnt_q + 16'd1;
        end
    end

    assign job_count = job_cnt_q;
`endif

endmodule
